// File: rtl/banco_registradores_if.sv
// Write/read bus of the register bank: decoder side is master, bank is slave.
interface banco_registradores_if #(
    parameter int LARGURA = 16,
    parameter int END_W   = 3
);
    logic               escritaEnable;
    logic [1:0]         modo;
    logic [END_W-1:0]   endEscrita;
    logic [LARGURA-1:0] dadoEscrita;
    logic [END_W-1:0]   endLeituraA;
    logic [END_W-1:0]   endLeituraB;
    logic [LARGURA-1:0] saidaA;
    logic [LARGURA-1:0] saidaB;
    logic               estouro;

    modport master (
        output escritaEnable, modo, endEscrita, dadoEscrita,
        output endLeituraA, endLeituraB,
        input  saidaA, saidaB, estouro
    );

    modport slave (
        input  escritaEnable, modo, endEscrita, dadoEscrita,
        input  endLeituraA, endLeituraB,
        output saidaA, saidaB, estouro
    );
endinterface

// File: rtl/banco_registradores.sv
// Register bank: one write port (load/inc/dec/clear), two registered reads.
// Define BANCO_REGS_BYPASS_EN to forward same-edge writes to the read ports.
module banco_registradores #(
    parameter int LARGURA  = 16,
    parameter int NUM_REGS = 8,
    parameter int END_W    = $clog2(NUM_REGS)
) (
    input  logic clock,
    input  logic reset,
    banco_registradores_if.slave bus
);
    logic [LARGURA-1:0] regs [NUM_REGS];
    logic               wr_ok;
    logic [LARGURA-1:0] atual;
    logic [LARGURA-1:0] novo;
    logic               wrap;
    logic [LARGURA-1:0] rd_a;
    logic [LARGURA-1:0] rd_b;

    always_comb begin
        wr_ok = bus.escritaEnable && (32'(bus.endEscrita) < NUM_REGS);
        atual = wr_ok ? regs[bus.endEscrita] : '0;
        novo  = '0;
        wrap  = 1'b0;
        unique case (bus.modo)
            2'b00: novo = bus.dadoEscrita;
            2'b01: begin
                novo = atual + 1'b1;
                wrap = &atual;
            end
            2'b10: begin
                novo = atual - 1'b1;
                wrap = (atual == '0);
            end
            2'b11: novo = '0;
        endcase
    end

    always_comb begin
        rd_a = (32'(bus.endLeituraA) < NUM_REGS) ? regs[bus.endLeituraA] : '0;
        rd_b = (32'(bus.endLeituraB) < NUM_REGS) ? regs[bus.endLeituraB] : '0;
`ifdef BANCO_REGS_BYPASS_EN
        if (wr_ok && bus.endLeituraA == bus.endEscrita) rd_a = novo;
        if (wr_ok && bus.endLeituraB == bus.endEscrita) rd_b = novo;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            bus.saidaA  <= '0;
            bus.saidaB  <= '0;
            bus.estouro <= 1'b0;
        end else begin
            if (wr_ok) regs[bus.endEscrita] <= novo;
            bus.saidaA  <= rd_a;
            bus.saidaB  <= rd_b;
            bus.estouro <= wr_ok && wrap;
        end
    end
endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores (7 regs so address 7 is out of range).
module tb_banco_registradores;
    localparam int LARG = 16;
    localparam int NREG = 7;
    localparam int EW   = 3;

`ifdef BANCO_REGS_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    typedef struct {
        logic [LARG-1:0] a;
        logic [LARG-1:0] b;
        logic            e;
        string           name;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    banco_registradores_if #(.LARGURA(LARG), .END_W(EW)) bus ();

    banco_registradores #(
        .LARGURA(LARG), .NUM_REGS(NREG), .END_W(EW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step(
        input logic rst, input logic en, input logic [1:0] md,
        input logic [EW-1:0] wa, input logic [LARG-1:0] wd,
        input logic [EW-1:0] ra, input logic [EW-1:0] rb,
        input logic [LARG-1:0] ea, input logic [LARG-1:0] eb,
        input logic ee, input string nm
    );
        exp_t x;
        @(negedge clock);
        reset             = rst;
        bus.escritaEnable = en;
        bus.modo          = md;
        bus.endEscrita    = wa;
        bus.dadoEscrita   = wd;
        bus.endLeituraA   = ra;
        bus.endLeituraB   = rb;
        @(posedge clock);
        x.a = ea; x.b = eb; x.e = ee; x.name = nm;
        sb.push_back(x);
    endtask

    // monitor: outputs are valid every cycle, sampled 1 time unit past the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_vec++;
                if (bus.saidaA !== x.a) begin
                    n_bad++;
                    $display("FAIL %s saidaA got %h want %h", x.name, bus.saidaA, x.a);
                end
                if (bus.saidaB !== x.b) begin
                    n_bad++;
                    $display("FAIL %s saidaB got %h want %h", x.name, bus.saidaB, x.b);
                end
                if (bus.estouro !== x.e) begin
                    n_bad++;
                    $display("FAIL %s estouro got %b want %b", x.name, bus.estouro, x.e);
                end
            end
        end
    end

    initial begin
        bus.escritaEnable = 1'b0;
        bus.modo = 2'b00;
        bus.endEscrita = '0;
        bus.dadoEscrita = '0;
        bus.endLeituraA = '0;
        bus.endLeituraB = '0;
        //   rst en  md     wa dado      ra rb  expA  expB  estouro
        step(1, 0, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, "rst0");
        step(1, 0, 2'b00, 0, 16'h0000, 3, 3, 16'h0000, 16'h0000, 0, "rst1");
        step(0, 1, 2'b00, 3, 16'h56ab, 3, 3,
             BP ? 16'h56ab : 16'h0000, BP ? 16'h56ab : 16'h0000, 0, "ld_r3");
        step(0, 0, 2'b00, 0, 16'h0000, 3, 3, 16'h56ab, 16'h56ab, 0, "rd_r3");
        step(1, 0, 2'b00, 0, 16'h0000, 3, 3, 16'h0000, 16'h0000, 0, "rst_mid");
        step(0, 0, 2'b00, 0, 16'h0000, 3, 3, 16'h0000, 16'h0000, 0, "r3_zero");
        step(0, 1, 2'b00, 1, 16'h56ab, 0, 0, 16'h0000, 16'h0000, 0, "ld_r1");
        step(0, 1, 2'b00, 2, 16'h0bff, 1, 1, 16'h56ab, 16'h56ab, 0, "ld_r2");
        step(0, 0, 2'b00, 1, 16'h98a3, 1, 2, 16'h56ab, 16'h0bff, 0, "en_low");
        step(0, 0, 2'b00, 0, 16'h0000, 1, 2, 16'h56ab, 16'h0bff, 0, "en_low_hold");
        step(0, 1, 2'b00, 4, 16'hffff, 4, 0,
             BP ? 16'hffff : 16'h0000, 16'h0000, 0, "ld_r4");
        step(0, 1, 2'b01, 4, 16'h0000, 4, 4,
             BP ? 16'h0000 : 16'hffff, BP ? 16'h0000 : 16'hffff, 1, "inc_wrap");
        step(0, 0, 2'b00, 0, 16'h0000, 4, 5, 16'h0000, 16'h0000, 0, "inc_pulse_end");
        step(0, 1, 2'b10, 5, 16'h0000, 5, 4,
             BP ? 16'hffff : 16'h0000, 16'h0000, 1, "dec_wrap");
        step(0, 0, 2'b00, 0, 16'h0000, 5, 5, 16'hffff, 16'hffff, 0, "dec_pulse_end");
        step(0, 1, 2'b00, 6, 16'h1234, 6, 0,
             BP ? 16'h1234 : 16'h0000, 16'h0000, 0, "ld_r6");
        step(0, 1, 2'b01, 6, 16'h0000, 6, 6,
             BP ? 16'h1235 : 16'h1234, BP ? 16'h1235 : 16'h1234, 0, "inc_nowrap");
        step(0, 1, 2'b10, 6, 16'h0000, 6, 0,
             BP ? 16'h1234 : 16'h1235, 16'h0000, 0, "dec_nowrap");
        step(0, 1, 2'b00, 6, 16'h5555, 6, 6,
             BP ? 16'h5555 : 16'h1234, BP ? 16'h5555 : 16'h1234, 0, "same_edge");
        step(0, 0, 2'b00, 0, 16'h0000, 6, 6, 16'h5555, 16'h5555, 0, "same_edge_next");
        step(0, 1, 2'b00, 7, 16'h9999, 7, 6, 16'h0000, 16'h5555, 0, "oor_load");
        step(0, 1, 2'b01, 7, 16'h0000, 7, 6, 16'h0000, 16'h5555, 0, "oor_inc");
        step(0, 1, 2'b10, 7, 16'h0000, 7, 7, 16'h0000, 16'h0000, 0, "oor_dec");
        step(0, 1, 2'b11, 6, 16'h0000, 6, 1,
             BP ? 16'h0000 : 16'h5555, 16'h56ab, 0, "clear_r6");
        step(0, 0, 2'b00, 0, 16'h0000, 6, 2, 16'h0000, 16'h0bff, 0, "clear_read");
        step(1, 1, 2'b00, 1, 16'h7777, 1, 2, 16'h0000, 16'h0000, 0, "rst_drop_wr");
        step(0, 0, 2'b00, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0, "after_rst");
        step(0, 1, 2'b10, 1, 16'h0000, 2, 1,
             16'h0000, BP ? 16'hffff : 16'h0000, 1, "dec_after_rst");
        step(0, 0, 2'b00, 0, 16'h0000, 1, 1, 16'hffff, 16'hffff, 0, "final_rd");
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain queue left %0d want 0", sb.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #100000;
                n_bad++;
                $display("FAIL timeout done got 0 want 1");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
